// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: parametrised ATM session controller.
// Owns the per-account balance/PIN store, authenticates a card session with
// per-account retry lockout, then serves operations until exit or idle timeout.
// Optional feature macro: ATM_WD_LIMIT_EN (per-session cumulative withdrawal cap).
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_start            card-insert strobe (IDLE only) with i_acc_num, i_pin
//   i_op_valid         operation strobe (MENU only) with i_operation, i_amount, i_new_pin
//   o_balance          balance of the session account (registered)
//   o_done             one-cycle result strobe
//   o_success          result qualifier, held until the next o_done
//   o_err_code         0 ok, 1 bad acc, 2 wrong PIN, 3 locked, 4 funds,
//                      5 overflow, 6 timeout, 7 invalid op/limit
//   o_in_session       high in MENU and EXEC
module atm_session_ctrl #(
    parameter int unsigned NUM_ACC   = 10,
    parameter int unsigned ACC_W     = 4,
    parameter int unsigned BAL_W     = 32,
    parameter int unsigned PIN_W     = 16,
    parameter int unsigned MAX_TRIES = 3,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned WD_LIMIT  = 5000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [ACC_W-1:0] i_acc_num,
    input  logic [PIN_W-1:0] i_pin,
    input  logic             i_op_valid,
    input  logic [2:0]       i_operation,
    input  logic [BAL_W-1:0] i_amount,
    input  logic [PIN_W-1:0] i_new_pin,
    output logic [BAL_W-1:0] o_balance,
    output logic             o_done,
    output logic             o_success,
    output logic [2:0]       o_err_code,
    output logic             o_in_session
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_BAL  = 3'd1;
    localparam logic [2:0] OP_WD   = 3'd2;
    localparam logic [2:0] OP_DEP  = 3'd3;
    localparam logic [2:0] OP_PIN  = 3'd4;
    localparam logic [2:0] OP_EXIT = 3'd5;

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_BAD_ACC = 3'd1;
    localparam logic [2:0] ERR_PIN     = 3'd2;
    localparam logic [2:0] ERR_LOCKED  = 3'd3;
    localparam logic [2:0] ERR_FUNDS   = 3'd4;
    localparam logic [2:0] ERR_OVF     = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT = 3'd6;
    localparam logic [2:0] ERR_INVALID = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AUTH,
        S_MENU,
        S_EXEC
    } state_t;

    // Account database
    logic [BAL_W-1:0] r_bal_db  [NUM_ACC];
    logic [PIN_W-1:0] r_pin_db  [NUM_ACC];
    logic [2:0]       r_fail    [NUM_ACC];
    logic [NUM_ACC-1:0] r_lock;

    // Session / control registers
    state_t            r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [PIN_W-1:0]  r_pin;
    logic [2:0]        r_op;
    logic [BAL_W-1:0]  r_amount;
    logic [PIN_W-1:0]  r_new_pin;
    logic [IDLE_W-1:0] r_idle_cnt;

    // Output registers
    logic [BAL_W-1:0]  r_balance;
    logic              r_done;
    logic              r_success;
    logic [2:0]        r_err;
    logic              r_in_session;

    // Next-state values
    state_t            w_state_nxt;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic [PIN_W-1:0]  w_pin_nxt;
    logic [2:0]        w_op_nxt;
    logic [BAL_W-1:0]  w_amount_nxt;
    logic [PIN_W-1:0]  w_new_pin_nxt;
    logic [IDLE_W-1:0] w_idle_nxt;
    logic [BAL_W-1:0]  w_balance_nxt;
    logic              w_done_nxt;
    logic              w_success_nxt;
    logic [2:0]        w_err_nxt;
    logic              w_in_session_nxt;

    // Database write controls (always addressed by the session account r_acc)
    logic              w_bal_we;
    logic [BAL_W-1:0]  w_bal_wdata;
    logic              w_pin_we;
    logic              w_fail_we;
    logic [2:0]        w_fail_wdata;
    logic              w_lock_set;

    // Datapath
    logic [BAL_W-1:0]  w_cur_bal;
    logic [PIN_W-1:0]  w_cur_pin;
    logic [2:0]        w_fail_inc;
    logic [BAL_W:0]    w_dep_sum;
    logic              w_wd_over;

    assign w_cur_bal  = r_bal_db[r_acc];
    assign w_cur_pin  = r_pin_db[r_acc];
    assign w_fail_inc = r_fail[r_acc] + 3'd1;
    // Extra top bit captures the carry out of BAL_W for overflow detection
    assign w_dep_sum  = {1'b0, w_cur_bal} + {1'b0, r_amount};

`ifdef ATM_WD_LIMIT_EN
    logic [BAL_W-1:0] r_wd_acc;
    logic [BAL_W-1:0] w_wd_acc_nxt;
    logic [BAL_W:0]   w_wd_sum;

    assign w_wd_sum  = {1'b0, r_wd_acc} + {1'b0, r_amount};
    assign w_wd_over = (w_wd_sum > (BAL_W+1)'(WD_LIMIT));
`else
    logic w_unused_wd_limit;

    assign w_unused_wd_limit = ^BAL_W'(WD_LIMIT);
    assign w_wd_over         = 1'b0;
`endif

    // Next-state, output and database-write decisions
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_pin_nxt     = r_pin;
        w_op_nxt      = r_op;
        w_amount_nxt  = r_amount;
        w_new_pin_nxt = r_new_pin;
        w_idle_nxt    = '0;
        w_balance_nxt = r_balance;
        w_done_nxt    = 1'b0;
        w_success_nxt = r_success;
        w_err_nxt     = r_err;
        w_bal_we      = 1'b0;
        w_bal_wdata   = w_cur_bal;
        w_pin_we      = 1'b0;
        w_fail_we     = 1'b0;
        w_fail_wdata  = '0;
        w_lock_set    = 1'b0;
`ifdef ATM_WD_LIMIT_EN
        w_wd_acc_nxt  = r_wd_acc;
`endif

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (32'(i_acc_num) >= NUM_ACC) begin
                        w_done_nxt    = 1'b1;
                        w_success_nxt = 1'b0;
                        w_err_nxt     = ERR_BAD_ACC;
                    end else if (r_lock[i_acc_num]) begin
                        w_done_nxt    = 1'b1;
                        w_success_nxt = 1'b0;
                        w_err_nxt     = ERR_LOCKED;
                    end else begin
                        w_acc_nxt   = i_acc_num;
                        w_pin_nxt   = i_pin;
                        w_state_nxt = S_AUTH;
                    end
                end
            end

            S_AUTH: begin
                w_done_nxt = 1'b1;
                w_fail_we  = 1'b1;
                if (r_pin == w_cur_pin) begin
                    w_fail_wdata  = '0;
                    w_success_nxt = 1'b1;
                    w_err_nxt     = ERR_OK;
                    w_balance_nxt = w_cur_bal;
                    w_state_nxt   = S_MENU;
`ifdef ATM_WD_LIMIT_EN
                    w_wd_acc_nxt  = '0;
`endif
                end else begin
                    w_fail_wdata  = w_fail_inc;
                    w_success_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                    if (w_fail_inc == 3'(MAX_TRIES)) begin
                        w_lock_set = 1'b1;
                        w_err_nxt  = ERR_LOCKED;
                    end else begin
                        w_err_nxt  = ERR_PIN;
                    end
                end
            end

            S_MENU: begin
                if (i_op_valid) begin
                    // An op strobe in the timeout cycle takes priority
                    w_op_nxt      = i_operation;
                    w_amount_nxt  = i_amount;
                    w_new_pin_nxt = i_new_pin;
                    w_state_nxt   = S_EXEC;
                end else if (r_idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                    w_done_nxt    = 1'b1;
                    w_success_nxt = 1'b0;
                    w_err_nxt     = ERR_TIMEOUT;
                    w_balance_nxt = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_idle_nxt = r_idle_cnt + IDLE_W'(1);
                end
            end

            S_EXEC: begin
                w_done_nxt    = 1'b1;
                w_state_nxt   = S_MENU;
                w_success_nxt = 1'b0;
                w_err_nxt     = ERR_INVALID;
                w_balance_nxt = w_cur_bal;
                case (r_op)
                    OP_BAL: begin
                        w_success_nxt = 1'b1;
                        w_err_nxt     = ERR_OK;
                    end
                    OP_WD: begin
                        if (r_amount == '0) begin
                            w_err_nxt = ERR_INVALID;
                        end else if (r_amount > w_cur_bal) begin
                            w_err_nxt = ERR_FUNDS;
                        end else if (w_wd_over) begin
                            w_err_nxt = ERR_INVALID;
                        end else begin
                            w_bal_we      = 1'b1;
                            w_bal_wdata   = w_cur_bal - r_amount;
                            w_balance_nxt = w_cur_bal - r_amount;
                            w_success_nxt = 1'b1;
                            w_err_nxt     = ERR_OK;
`ifdef ATM_WD_LIMIT_EN
                            w_wd_acc_nxt  = r_wd_acc + r_amount;
`endif
                        end
                    end
                    OP_DEP: begin
                        if (r_amount == '0) begin
                            w_err_nxt = ERR_INVALID;
                        end else if (w_dep_sum[BAL_W]) begin
                            w_err_nxt = ERR_OVF;
                        end else begin
                            w_bal_we      = 1'b1;
                            w_bal_wdata   = w_dep_sum[BAL_W-1:0];
                            w_balance_nxt = w_dep_sum[BAL_W-1:0];
                            w_success_nxt = 1'b1;
                            w_err_nxt     = ERR_OK;
                        end
                    end
                    OP_PIN: begin
                        w_pin_we      = 1'b1;
                        w_success_nxt = 1'b1;
                        w_err_nxt     = ERR_OK;
                    end
                    OP_EXIT: begin
                        w_success_nxt = 1'b1;
                        w_err_nxt     = ERR_OK;
                        w_balance_nxt = '0;
                        w_state_nxt   = S_IDLE;
                    end
                    default: begin
                        w_err_nxt = ERR_INVALID;
                    end
                endcase
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_in_session_nxt = (w_state_nxt == S_MENU) || (w_state_nxt == S_EXEC);
    end

    // State, output and database registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_pin        <= '0;
            r_op         <= '0;
            r_amount     <= '0;
            r_new_pin    <= '0;
            r_idle_cnt   <= '0;
            r_balance    <= '0;
            r_done       <= 1'b0;
            r_success    <= 1'b0;
            r_err        <= '0;
            r_in_session <= 1'b0;
            r_lock       <= '0;
`ifdef ATM_WD_LIMIT_EN
            r_wd_acc     <= '0;
`endif
            for (int unsigned i = 0; i < NUM_ACC; i++) begin
                r_bal_db[ACC_W'(i)] <= BAL_W'((i + 1) * 1000);
                r_pin_db[ACC_W'(i)] <= PIN_W'(32'h1000 + i);
                r_fail[ACC_W'(i)]   <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_pin        <= w_pin_nxt;
            r_op         <= w_op_nxt;
            r_amount     <= w_amount_nxt;
            r_new_pin    <= w_new_pin_nxt;
            r_idle_cnt   <= w_idle_nxt;
            r_balance    <= w_balance_nxt;
            r_done       <= w_done_nxt;
            r_success    <= w_success_nxt;
            r_err        <= w_err_nxt;
            r_in_session <= w_in_session_nxt;
`ifdef ATM_WD_LIMIT_EN
            r_wd_acc     <= w_wd_acc_nxt;
`endif
            if (w_bal_we) begin
                r_bal_db[r_acc] <= w_bal_wdata;
            end
            if (w_pin_we) begin
                r_pin_db[r_acc] <= r_new_pin;
            end
            if (w_fail_we) begin
                r_fail[r_acc] <= w_fail_wdata;
            end
            if (w_lock_set) begin
                r_lock[r_acc] <= 1'b1;
            end
        end
    end

    assign o_balance    = r_balance;
    assign o_done       = r_done;
    assign o_success    = r_success;
    assign o_err_code   = r_err;
    assign o_in_session = r_in_session;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl (TIMEOUT overridden to 8).
module tb_atm_session_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic        op_valid;
    logic [2:0]  operation;
    logic [31:0] amount;
    logic [15:0] new_pin;
    logic [31:0] balance;
    logic        done;
    logic        success;
    logic [2:0]  err_code;
    logic        in_session;

    int n_chk = 0;
    int n_err = 0;

    atm_session_ctrl #(
        .NUM_ACC   (10),
        .ACC_W     (4),
        .BAL_W     (32),
        .PIN_W     (16),
        .MAX_TRIES (3),
        .TIMEOUT   (8),
        .WD_LIMIT  (5000)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_acc_num    (acc_num),
        .i_pin        (pin),
        .i_op_valid   (op_valid),
        .i_operation  (operation),
        .i_amount     (amount),
        .i_new_pin    (new_pin),
        .o_balance    (balance),
        .o_done       (done),
        .o_success    (success),
        .o_err_code   (err_code),
        .o_in_session (in_session)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Called #1 after the sample edge; checks done latency, result and pulse width
    task automatic wait_done(input string tag, input int lat, input logic exp_succ,
                             input logic [2:0] exp_err, input logic [31:0] exp_bal,
                             input logic exp_sess);
        for (int i = 1; i < lat; i++) begin
            chk({tag, ".early"}, 64'(done), 64'd0);
            @(posedge clk); #1;
        end
        chk({tag, ".done"},  64'(done),       64'd1);
        chk({tag, ".succ"},  64'(success),    64'(exp_succ));
        chk({tag, ".err"},   64'(err_code),   64'(exp_err));
        chk({tag, ".bal"},   64'(balance),    64'(exp_bal));
        chk({tag, ".sess"},  64'(in_session), 64'(exp_sess));
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 64'(done), 64'd0);
    endtask

    task automatic start_txn(input string tag, input logic [3:0] a, input logic [15:0] p,
                             input int lat, input logic exp_succ, input logic [2:0] exp_err,
                             input logic [31:0] exp_bal, input logic exp_sess);
        @(posedge clk); #1;
        start = 1'b1; acc_num = a; pin = p;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(tag, lat, exp_succ, exp_err, exp_bal, exp_sess);
    endtask

    task automatic op_txn(input string tag, input logic [2:0] op, input logic [31:0] amt,
                          input logic [15:0] np, input logic exp_succ, input logic [2:0] exp_err,
                          input logic [31:0] exp_bal, input logic exp_sess);
        @(posedge clk); #1;
        op_valid = 1'b1; operation = op; amount = amt; new_pin = np;
        @(posedge clk); #1;
        op_valid = 1'b0;
        wait_done(tag, 2, exp_succ, exp_err, exp_bal, exp_sess);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk({tag, ".bal"},  64'(balance),    64'd0);
        chk({tag, ".done"}, 64'(done),       64'd0);
        chk({tag, ".succ"}, 64'(success),    64'd0);
        chk({tag, ".err"},  64'(err_code),   64'd0);
        chk({tag, ".sess"}, 64'(in_session), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; acc_num = '0; pin = '0;
        op_valid = 1'b0; operation = '0; amount = '0; new_pin = '0;
        @(posedge clk);
        do_reset("reset");

        // Basic login / exit
        start_txn("login2", 4'd2, 16'h1002, 2, 1'b1, 3'd0, 32'd3000, 1'b1);
        op_txn("exit2", 3'd5, 32'd0, 16'h0, 1'b1, 3'd0, 32'd0, 1'b0);

        // Lockout after three wrong PINs, cleared only by reset
        start_txn("bad0a", 4'd0, 16'h0000, 2, 1'b0, 3'd2, 32'd0, 1'b0);
        start_txn("bad0b", 4'd0, 16'h0000, 2, 1'b0, 3'd2, 32'd0, 1'b0);
        start_txn("bad0c", 4'd0, 16'h0000, 2, 1'b0, 3'd3, 32'd0, 1'b0);
        start_txn("lock0", 4'd0, 16'h1000, 1, 1'b0, 3'd3, 32'd0, 1'b0);
        do_reset("reset2");
        start_txn("login0", 4'd0, 16'h1000, 2, 1'b1, 3'd0, 32'd1000, 1'b1);
        op_txn("exit0", 3'd5, 32'd0, 16'h0, 1'b1, 3'd0, 32'd0, 1'b0);

        // Withdraw / deposit boundaries on account 1
        start_txn("login1", 4'd1, 16'h1001, 2, 1'b1, 3'd0, 32'd2000, 1'b1);
        op_txn("wd2500",  3'd2, 32'd2500, 16'h0, 1'b0, 3'd4, 32'd2000, 1'b1);
        op_txn("wd500",   3'd2, 32'd500,  16'h0, 1'b1, 3'd0, 32'd1500, 1'b1);
        op_txn("depmax",  3'd3, 32'hFFFF_FFFF, 16'h0, 1'b0, 3'd5, 32'd1500, 1'b1);
        op_txn("dep100",  3'd3, 32'd100,  16'h0, 1'b1, 3'd0, 32'd1600, 1'b1);
        op_txn("wd0",     3'd2, 32'd0,    16'h0, 1'b0, 3'd7, 32'd1600, 1'b1);
        op_txn("dep0",    3'd3, 32'd0,    16'h0, 1'b0, 3'd7, 32'd1600, 1'b1);
        op_txn("badop",   3'd6, 32'd5,    16'h0, 1'b0, 3'd7, 32'd1600, 1'b1);
        op_txn("balq",    3'd1, 32'd0,    16'h0, 1'b1, 3'd0, 32'd1600, 1'b1);
        op_txn("wdall",   3'd2, 32'd1600, 16'h0, 1'b1, 3'd0, 32'd0,    1'b1);
        op_txn("depfull", 3'd3, 32'hFFFF_FFFF, 16'h0, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b1);
        op_txn("dep1ovf", 3'd3, 32'd1,    16'h0, 1'b0, 3'd5, 32'hFFFF_FFFF, 1'b1);
        op_txn("exit1",   3'd5, 32'd0,    16'h0, 1'b1, 3'd0, 32'd0,    1'b0);

        // PIN change on account 4
        start_txn("login4", 4'd4, 16'h1004, 2, 1'b1, 3'd0, 32'd5000, 1'b1);
        op_txn("chpin",   3'd4, 32'd0, 16'hBEEF, 1'b1, 3'd0, 32'd5000, 1'b1);
        op_txn("exit4",   3'd5, 32'd0, 16'h0, 1'b1, 3'd0, 32'd0, 1'b0);
        start_txn("old4", 4'd4, 16'h1004, 2, 1'b0, 3'd2, 32'd0, 1'b0);
        start_txn("new4", 4'd4, 16'hBEEF, 2, 1'b1, 3'd0, 32'd5000, 1'b1);
        op_txn("exit4b",  3'd5, 32'd0, 16'h0, 1'b1, 3'd0, 32'd0, 1'b0);

        // Reset during EXEC discards the pending deposit
        start_txn("login5", 4'd5, 16'h1005, 2, 1'b1, 3'd0, 32'd6000, 1'b1);
        @(posedge clk); #1;
        op_valid = 1'b1; operation = 3'd3; amount = 32'd1000;
        @(posedge clk); #1;
        op_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstexec.done", 64'(done), 64'd0);
        chk("rstexec.bal",  64'(balance), 64'd0);
        chk("rstexec.sess", 64'(in_session), 64'd0);
        start_txn("relog5", 4'd5, 16'h1005, 2, 1'b1, 3'd0, 32'd6000, 1'b1);
        op_txn("exit5",   3'd5, 32'd0, 16'h0, 1'b1, 3'd0, 32'd0, 1'b0);
        start_txn("pin4rst", 4'd4, 16'h1004, 2, 1'b1, 3'd0, 32'd5000, 1'b1);
        op_txn("exit4c",  3'd5, 32'd0, 16'h0, 1'b1, 3'd0, 32'd0, 1'b0);

        // Withdrawal cap (or plain balance-limited withdrawal)
        start_txn("login9", 4'd9, 16'h1009, 2, 1'b1, 3'd0, 32'd10000, 1'b1);
        op_txn("wd3000",  3'd2, 32'd3000, 16'h0, 1'b1, 3'd0, 32'd7000, 1'b1);
`ifdef ATM_WD_LIMIT_EN
        op_txn("wd2500lim", 3'd2, 32'd2500, 16'h0, 1'b0, 3'd7, 32'd7000, 1'b1);
`else
        op_txn("wd2500ok",  3'd2, 32'd2500, 16'h0, 1'b1, 3'd0, 32'd4500, 1'b1);
`endif
        op_txn("exit9",   3'd5, 32'd0, 16'h0, 1'b1, 3'd0, 32'd0, 1'b0);

        // op_valid in the 8th idle cycle beats the timeout
        start_txn("login3", 4'd3, 16'h1003, 2, 1'b1, 3'd0, 32'd4000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("opwin.idle", 64'(done), 64'd0);
        end
        op_valid = 1'b1; operation = 3'd1; amount = '0;
        @(posedge clk); #1;
        op_valid = 1'b0;
        wait_done("opwin", 2, 1'b1, 3'd0, 32'd4000, 1'b1);

        // Idle timeout: fires on the 8th consecutive idle MENU cycle
        op_txn("exit3", 3'd5, 32'd0, 16'h0, 1'b1, 3'd0, 32'd0, 1'b0);
        start_txn("login3b", 4'd3, 16'h1003, 2, 1'b1, 3'd0, 32'd4000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("tmo.idle", 64'(done), 64'd0);
        end
        @(posedge clk); #1;
        chk("tmo.done", 64'(done),       64'd1);
        chk("tmo.succ", 64'(success),    64'd0);
        chk("tmo.err",  64'(err_code),   64'd6);
        chk("tmo.bal",  64'(balance),    64'd0);
        chk("tmo.sess", 64'(in_session), 64'd0);

        // Out-of-range account
        start_txn("acc12", 4'd12, 16'h1000, 1, 1'b0, 3'd1, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Parametrised ATM session controller: the next-generation replacement for the fixed 10-account ATM FSM. It owns the account balance and PIN store, authenticates a card session with per-account retry lockout, then serves any number of operations per session until exit or idle timeout. It sits between the front-panel input logic and the display/receipt logic; all results are reported through a single-cycle `done` strobe.

## Interface
- `NUM_ACC`, 10: number of accounts (2..16).
- `ACC_W`, 4: account-number width; must satisfy 2^`ACC_W` >= `NUM_ACC`.
- `BAL_W`, 32: balance and amount width.
- `PIN_W`, 16: PIN width.
- `MAX_TRIES`, 3: consecutive wrong PINs that lock an account (1..7).
- `TIMEOUT`, 1024: idle cycles in MENU before forced logout.
- `WD_LIMIT`, 5000: per-session cumulative withdrawal cap; used only under `ATM_WD_LIMIT_EN`.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: card-insert strobe, sampled only in IDLE.
- `acc_num` in `ACC_W`: account index, sampled with `start`.
- `pin` in `PIN_W`: entered PIN, sampled with `start`.
- `op_valid` in 1: operation strobe, sampled only in MENU.
- `operation` in 3: 1 balance, 2 withdraw, 3 deposit, 4 change PIN, 5 exit; other values are invalid.
- `amount` in `BAL_W`: withdraw/deposit amount, sampled with `op_valid`.
- `new_pin` in `PIN_W`: replacement PIN, sampled with `op_valid`.
- `balance` out `BAL_W`: balance of the session account, registered.
- `done` out 1: one-cycle result strobe.
- `success` out 1: qualifies `done`; holds its value until the next `done`.
- `err_code` out 3: 0 ok, 1 bad account, 2 wrong PIN, 3 locked, 4 insufficient funds, 5 overflow, 6 timeout, 7 invalid op/limit.
- `in_session` out 1: high in MENU and EXEC.

## Operation
- States: IDLE, AUTH, MENU, EXEC.
- Reset values:
  - All outputs are 0; state is IDLE.
  - `balance_db[i]` = (i+1)*1000.
  - `pin_db[i]` = 16'h1000+i, zero-extended or truncated to `PIN_W`.
  - All failure counters and lock bits are cleared.
- IDLE:
  - `start` with `acc_num` >= `NUM_ACC`: `done`, err 1, stay in IDLE.
  - `start` on a locked account: `done`, err 3, stay in IDLE.
  - Otherwise latch `acc_num` and `pin`, then go to AUTH.
- AUTH:
  - PIN match: clear that account's fail counter, `done`, `success`=1, `balance`=stored balance, go to MENU.
  - Mismatch: increment the fail counter. When it reaches `MAX_TRIES`, set the lock bit and report err 3; otherwise report err 2. Go to IDLE.
- MENU:
  - `op_valid` latches `operation`, `amount` and `new_pin`, clears the idle counter, and goes to EXEC.
  - Each cycle without `op_valid` increments the idle counter. When it reaches `TIMEOUT`: `done`, err 6, `balance`=0, go to IDLE.
- EXEC (one cycle), then return to MENU unless noted:
  - Balance: `success`=1.
  - Withdraw: fails with err 4 if `amount` > balance; fails with err 7 if `amount`==0. Otherwise subtract.
  - Deposit: fails with err 5 if the sum carries out of `BAL_W` bits; fails with err 7 if `amount`==0. Otherwise add.
  - Change PIN: write `new_pin`, `success`=1.
  - Exit: `success`=1, `balance`=0, go to IDLE.
  - Invalid code: err 7.
  - `balance` always shows the post-operation value; on failure the stored value is unchanged.
- `start` outside IDLE and `op_valid` outside MENU are ignored.
- Lock bits persist until `rst`.

## Timing
- Results are registered. `done` is high for exactly the one cycle after the decision edge.
- Bad/locked account in IDLE: `done` 1 cycle after the `start` sample edge.
- Authentication: `done` 2 cycles after the `start` sample edge.
- Operation: `done` 2 cycles after the `op_valid` sample edge. The next `op_valid` may be accepted in the cycle `done` is high.
- Timeout fires on the `TIMEOUT`-th consecutive idle MENU cycle. `op_valid` in that same cycle wins and the counter clears.
- `rst` overrides everything, including an EXEC in flight. The database returns to its reset contents; a pending write is discarded.

## Configuration
- `ATM_WD_LIMIT_EN` defined:
  - A `BAL_W`-bit session accumulator clears on each entry to MENU from AUTH.
  - A withdraw whose accumulator+`amount` exceeds `WD_LIMIT` fails with err 7, balance unchanged.
  - A successful withdraw adds `amount` to the accumulator.
- `ATM_WD_LIMIT_EN` undefined: no accumulator; withdrawals are limited only by balance.

## Test plan
- Reset, `start` acc 2 PIN 16'h1002 -> `done`, `success`=1, `balance`=3000, 2 cycles later; then op 5 -> `success`=1, `balance`=0, back in IDLE.
- Acc 0 with PIN 16'h0000 three times -> err 2, err 2, err 3; a fourth try with correct PIN 16'h1000 -> err 3; after `rst`, correct PIN -> `success`.
- Acc 1 session: withdraw 2500 -> err 4, `balance`=2000; withdraw 500 -> 1500; deposit 2^32-1 -> err 5, `balance`=1500.
- Change PIN of acc 4 to 16'hBEEF, exit, log in with 16'h1004 -> err 2; log in with 16'hBEEF -> `success`.
- `TIMEOUT`=8: log in, idle 8 cycles -> `done`, err 6, `in_session`=0; `start` with `acc_num`=12 -> err 1 after 1 cycle.
- With `ATM_WD_LIMIT_EN`: acc 9, withdraw 3000 then 2500 -> ok then err 7, `balance`=7000.
